// File: rtl/uart_param.sv
// Parametrised full-duplex UART with a show-ahead RX FIFO carrying
// per-entry frame/parity error flags and a sticky overrun flag.
module uart_param #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 transmit,
  input  logic [DATA_BITS-1:0] data_tx,
  output logic                 busy_tx,
  output logic                 tx,
  input  logic                 rx,
  input  logic                 rx_pop,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] data_rx,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 ovr_clr
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
  localparam int unsigned BIT_W        = $clog2(DATA_BITS);
  localparam int unsigned ENTRY_W      = DATA_BITS + 2;
  localparam int unsigned ADDR_W       = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W        = ADDR_W + 1;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  // ---------------------------------------------------------------- TX path
  tx_state_e              tx_state_q, tx_state_d;
  logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]       tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_sh_q, tx_sh_d;
  logic                   tx_par_q, tx_par_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;

  // TX state register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  // TX next state: line level is registered one bit ahead of each state change
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (transmit) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_sh_d    = data_tx;
          tx_par_d   = (PARITY == 1) ? ~^data_tx : ^data_tx;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_sh_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              tx_state_d = TX_PARITY;
              tx_d       = tx_par_q;
            end else begin
              tx_state_d = TX_STOP;
              tx_d       = 1'b1;
            end
          end else begin
            tx_bit_d = tx_bit_q + BIT_W'(1);
            tx_sh_d  = tx_sh_q >> 1;
            tx_d     = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_PARITY: begin
        if (tx_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          tx_state_d = TX_STOP;
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_W'(STOP_BITS * CLKS_PER_BIT - 1)) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
          busy_d     = 1'b0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign tx      = tx_q;
  assign busy_tx = busy_q;

  // ---------------------------------------------------------------- RX path
  logic                   rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e              rx_state_q, rx_state_d;
  logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]       rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_sh_q, rx_sh_d;
  logic                   rx_par_q, rx_par_d;
  logic                   rx_perr_c;
  logic                   push_c;
  logic [ENTRY_W-1:0]     entry_c;

  // Two-flop synchroniser plus a history flop for start-edge detection
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // RX state register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
    end
  end

  // Parity check over received data plus the sampled parity bit
  always_comb begin
    rx_perr_c = 1'b0;
    if (PARITY == 2)      rx_perr_c = ^{rx_sh_q, rx_par_q};
    else if (PARITY == 1) rx_perr_c = ~^{rx_sh_q, rx_par_q};
  end

  // RX next state: count down to each bit centre, push at the first stop bit
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    push_c     = 1'b0;
    entry_c    = {rx_perr_c, ~rx_s2_q, rx_sh_q};
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = CNT_W'(CLKS_PER_BIT / 2);
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_s2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
          rx_cnt_d = CNT_W'(CLKS_PER_BIT - 1);
          if (rx_bit_q == BIT_W'(DATA_BITS - 1)) begin
            rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + BIT_W'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      RX_PARITY: begin
        if (rx_cnt_q == '0) begin
          rx_par_d   = rx_s2_q;
          rx_state_d = RX_STOP;
          rx_cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          push_c     = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W-1:0]   count_c;
  logic               full_c, empty_c, pop_c, wr_en_c, ovr_set_c;
  logic [ADDR_W-1:0]  head_idx_c;
  logic [ENTRY_W-1:0] head_q, head_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;

  // FIFO control and next head, so the show-ahead outputs can be registered
  always_comb begin
    count_c    = wr_q - rd_q;
    full_c     = (count_c == PTR_W'(FIFO_DEPTH));
    empty_c    = (wr_q == rd_q);
    pop_c      = rx_pop && !empty_c;
    wr_en_c    = push_c && (!full_c || pop_c);
    ovr_set_c  = push_c && full_c && !pop_c;
    wr_d       = wr_q + PTR_W'(wr_en_c);
    rd_d       = rd_q + PTR_W'(pop_c);
    head_idx_c = rd_d[ADDR_W-1:0];
    valid_d    = (wr_d != rd_d);
    head_d     = '0;
    if (valid_d) begin
      if (wr_en_c && (wr_q[ADDR_W-1:0] == head_idx_c)) head_d = entry_c;
      else                                             head_d = mem_q[head_idx_c];
    end
    ovr_d = ovr_q;
    if (ovr_clr)   ovr_d = 1'b0;
    if (ovr_set_c) ovr_d = 1'b1;
  end

  // FIFO storage, pointers and registered head/status
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (wr_en_c) mem_q[wr_q[ADDR_W-1:0]] <= entry_c;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      head_q  <= head_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_valid   = valid_q;
  assign data_rx    = head_q[DATA_BITS-1:0];
  assign frame_err  = head_q[DATA_BITS];
  assign parity_err = head_q[DATA_BITS+1];
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param: 8N1 instance (A) driven from the bench,
// 8E2 instance (B) in loopback, 8O1 instance (C) for parity errors.
module tb_uart_param;

  logic       clk;
  logic       nRst;
  logic       rx_drv;
  logic       rx_sel;
  int         checks;
  int         errors;

  // instance A: 8N1, CLKS_PER_BIT = 16
  logic       transmit_a, busy_a, tx_a, rx_a, rx_pop_a, rx_valid_a;
  logic       ferr_a, perr_a, ovr_a, ovr_clr_a;
  logic [7:0] data_tx_a, data_rx_a;
  // instance B: 8E2 loopback
  logic       transmit_b, busy_b, tx_b, rx_pop_b, rx_valid_b;
  logic       ferr_b, perr_b, ovr_b, ovr_clr_b;
  logic [7:0] data_tx_b, data_rx_b;
  // instance C: 8O1 receive only
  logic       transmit_c, busy_c, tx_c, rx_c, rx_pop_c, rx_valid_c;
  logic       ferr_c, perr_c, ovr_c, ovr_clr_c;
  logic [7:0] data_tx_c, data_rx_c;

  assign rx_a = rx_sel ? 1'b1 : rx_drv;
  assign rx_c = rx_sel ? rx_drv : 1'b1;

  uart_param #(.CLK_HZ(16), .BAUD(1)) dut_a (
    .clk(clk), .nRst(nRst), .transmit(transmit_a), .data_tx(data_tx_a),
    .busy_tx(busy_a), .tx(tx_a), .rx(rx_a), .rx_pop(rx_pop_a),
    .rx_valid(rx_valid_a), .data_rx(data_rx_a), .frame_err(ferr_a),
    .parity_err(perr_a), .overrun(ovr_a), .ovr_clr(ovr_clr_a));

  uart_param #(.CLK_HZ(16), .BAUD(1), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .nRst(nRst), .transmit(transmit_b), .data_tx(data_tx_b),
    .busy_tx(busy_b), .tx(tx_b), .rx(tx_b), .rx_pop(rx_pop_b),
    .rx_valid(rx_valid_b), .data_rx(data_rx_b), .frame_err(ferr_b),
    .parity_err(perr_b), .overrun(ovr_b), .ovr_clr(ovr_clr_b));

  uart_param #(.CLK_HZ(16), .BAUD(1), .PARITY(1)) dut_c (
    .clk(clk), .nRst(nRst), .transmit(transmit_c), .data_tx(data_tx_c),
    .busy_tx(busy_c), .tx(tx_c), .rx(rx_c), .rx_pop(rx_pop_c),
    .rx_valid(rx_valid_c), .data_rx(data_rx_c), .frame_err(ferr_c),
    .parity_err(perr_c), .overrun(ovr_c), .ovr_clr(ovr_clr_c));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // head = {valid, parity_err, frame_err, data}
  task automatic check_head(input int which, input string tag,
                            input logic perr, input logic ferr, input logic [7:0] d);
    logic [31:0] obs;
    case (which)
      0:       obs = {21'd0, rx_valid_a, perr_a, ferr_a, data_rx_a};
      1:       obs = {21'd0, rx_valid_b, perr_b, ferr_b, data_rx_b};
      default: obs = {21'd0, rx_valid_c, perr_c, ferr_c, data_rx_c};
    endcase
    check(tag, obs, {21'd0, 1'b1, perr, ferr, d});
  endtask

  task automatic pop(input int which);
    @(posedge clk); #1;
    rx_pop_a = (which == 0);
    rx_pop_b = (which == 1);
    rx_pop_c = (which == 2);
    @(posedge clk); #1;
    rx_pop_a = 1'b0;
    rx_pop_b = 1'b0;
    rx_pop_c = 1'b0;
  endtask

  task automatic wait_busy_b(input logic lvl, input string tag);
    int n;
    n = 0;
    while (busy_b !== lvl && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, {31'd0, busy_b}, {31'd0, lvl});
  endtask

  // Drive one serial frame on rx_drv; pop A on cycle pop_at; ncyc>0 aborts early
  task automatic drive_rx(input logic [7:0] d, input int par_mode, input logic par_flip,
                          input logic stop_val, input int pop_at, input int ncyc);
    logic [10:0] fr;
    int nb;
    int lim;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = d;
    nb = 9;
    if (par_mode != 0) begin
      fr[9] = ((par_mode == 1) ? ~^d : ^d) ^ par_flip;
      nb = 10;
    end
    fr[nb] = stop_val;
    nb++;
    lim = (ncyc > 0) ? ncyc : nb * 16;
    for (int c = 0; c < lim; c++) begin
      @(posedge clk); #1;
      rx_drv = fr[c / 16];
      rx_pop_a = (c == pop_at);
    end
    @(posedge clk); #1;
    rx_drv = 1'b1;
    rx_pop_a = 1'b0;
  endtask

  initial begin
    logic [9:0] exp_bits;
    int busy_cnt;
    checks = 0;
    errors = 0;
    clk = 1'b0;
    nRst = 1'b0;
    rx_drv = 1'b1;
    rx_sel = 1'b0;
    transmit_a = 1'b0; data_tx_a = '0; rx_pop_a = 1'b0; ovr_clr_a = 1'b0;
    transmit_b = 1'b0; data_tx_b = '0; rx_pop_b = 1'b0; ovr_clr_b = 1'b0;
    transmit_c = 1'b0; data_tx_c = '0; rx_pop_c = 1'b0; ovr_clr_c = 1'b0;

    // reset and idle
    repeat (3) @(posedge clk);
    #1 nRst = 1'b1;
    @(posedge clk); #1;
    check("rst_state", {27'd0, tx_a, busy_a, rx_valid_a, ovr_a, 1'b0},
          {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    check("rst_data_rx", {24'd0, data_rx_a}, 32'd0);
    repeat (100) @(posedge clk);
    #1;
    check("idle_state", {28'd0, tx_a, busy_a, rx_valid_a, ovr_a}, {28'd0, 4'b1000});

    // TX 8N1 0xAA: bit sequence and busy length
    @(posedge clk); #1;
    data_tx_a = 8'hAA;
    transmit_a = 1'b1;
    @(posedge clk); #1;
    transmit_a = 1'b0;
    exp_bits = 10'b1101010100; // index 0 = start bit
    busy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (i < 160 && (i % 16) == 8)
        check($sformatf("tx_aa_bit%0d", i / 16), {31'd0, tx_a}, {31'd0, exp_bits[i / 16]});
      if (busy_a) busy_cnt++;
      @(posedge clk); #1;
    end
    check("tx_busy_len", busy_cnt, 32'd160);
    check("tx_idle_after", {30'd0, tx_a, busy_a}, {30'd0, 2'b10});

    // loopback 8E2, back-to-back 5A, 01, FF
    data_tx_b = 8'h5A;
    transmit_b = 1'b1;
    wait_busy_b(1'b1, "lb_start0");
    data_tx_b = 8'h01;
    repeat (152) @(posedge clk);
    #1 check("lb_par0", {31'd0, tx_b}, 32'd0);
    wait_busy_b(1'b0, "lb_end0");
    @(posedge clk); #1;
    check("lb_gap0", {31'd0, busy_b}, 32'd1);
    data_tx_b = 8'hFF;
    repeat (152) @(posedge clk);
    #1 check("lb_par1", {31'd0, tx_b}, 32'd1);
    wait_busy_b(1'b0, "lb_end1");
    @(posedge clk); #1;
    check("lb_gap1", {31'd0, busy_b}, 32'd1);
    transmit_b = 1'b0;
    repeat (152) @(posedge clk);
    #1 check("lb_par2", {31'd0, tx_b}, 32'd0);
    wait_busy_b(1'b0, "lb_end2");
    repeat (20) @(posedge clk);
    #1;
    check_head(1, "lb_rx0", 1'b0, 1'b0, 8'h5A);
    pop(1);
    check_head(1, "lb_rx1", 1'b0, 1'b0, 8'h01);
    pop(1);
    check_head(1, "lb_rx2", 1'b0, 1'b0, 8'hFF);
    pop(1);
    check("lb_empty", {30'd0, rx_valid_b, ovr_b}, 32'd0);

    // glitch: 3-cycle low pulse produces nothing
    @(posedge clk); #1;
    rx_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (40) @(posedge clk);
    #1 check("glitch_none", {31'd0, rx_valid_a}, 32'd0);

    // stop bit forced low -> frame error
    drive_rx(8'h3C, 0, 1'b0, 1'b0, -1, 0);
    repeat (10) @(posedge clk);
    #1 check_head(0, "ferr_3c", 1'b0, 1'b1, 8'h3C);
    pop(0);
    check("ferr_popped", {31'd0, rx_valid_a}, 32'd0);

    // 8O1: correct parity then wrong parity
    rx_sel = 1'b1;
    drive_rx(8'h03, 1, 1'b0, 1'b1, -1, 0);
    drive_rx(8'h07, 1, 1'b1, 1'b1, -1, 0);
    repeat (10) @(posedge clk);
    #1 check_head(2, "par_ok", 1'b0, 1'b0, 8'h03);
    pop(2);
    check_head(2, "par_bad", 1'b1, 1'b0, 8'h07);
    pop(2);
    check("par_empty", {31'd0, rx_valid_c}, 32'd0);
    rx_sel = 1'b0;

    // overflow: 5 frames, no pop
    for (int i = 0; i < 5; i++) drive_rx(8'(8'h10 + i), 0, 1'b0, 1'b1, -1, 0);
    repeat (10) @(posedge clk);
    #1 check("ovr_set", {31'd0, ovr_a}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_head(0, $sformatf("ovr_head%0d", i), 1'b0, 1'b0, 8'(8'h10 + i));
      pop(0);
    end
    check("ovr_drained", {30'd0, rx_valid_a, ovr_a}, {30'd0, 2'b01});
    @(posedge clk); #1;
    ovr_clr_a = 1'b1;
    @(posedge clk); #1;
    ovr_clr_a = 1'b0;
    check("ovr_clr", {31'd0, ovr_a}, 32'd0);

    // reset during the 4th data bit of both TX and RX
    @(posedge clk); #1;
    data_tx_a = 8'hC3;
    transmit_a = 1'b1;
    @(posedge clk); #1;
    transmit_a = 1'b0;
    drive_rx(8'h55, 0, 1'b0, 1'b1, -1, 16 * 4 + 8);
    nRst = 1'b0;
    #1 check("midrst_async", {30'd0, tx_a, busy_a}, {30'd0, 2'b10});
    repeat (2) @(posedge clk);
    #1 nRst = 1'b1;
    repeat (200) @(posedge clk);
    #1 check("midrst_idle", {29'd0, tx_a, busy_a, rx_valid_a}, {29'd0, 3'b100});

    // fill to 4, then pop on the cycle the 5th frame is pushed
    for (int i = 0; i < 4; i++) drive_rx(8'(8'h20 + i), 0, 1'b0, 1'b1, -1, 0);
    repeat (5) @(posedge clk);
    #1 check_head(0, "full_head", 1'b0, 1'b0, 8'h20);
    drive_rx(8'h24, 0, 1'b0, 1'b1, 155, 0);
    repeat (10) @(posedge clk);
    #1 check("pp_no_ovr", {31'd0, ovr_a}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_head(0, $sformatf("pp_head%0d", i), 1'b0, 1'b0, 8'(8'h21 + i));
      pop(0);
    end
    check("pp_empty", {30'd0, rx_valid_a, ovr_a}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
- Parametrised full-duplex UART, the successor to the fixed 8N1 uart core.
- Configurable clock/baud ratio, data width, parity mode and stop-bit count.
- Adds a receive FIFO with per-entry frame/parity error flags and a sticky overrun flag.
- Sits between the FPGA top level's rx/tx pins and user logic; TX handshake matches the existing uart (transmit/busy_tx).

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated, must be ≥ 4.
- DATA_BITS, 8, payload bits per frame, legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame, 1 or 2.
- FIFO_DEPTH, 4, RX FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock.
- nRst  in  1  asynchronous active-low reset.
- transmit  in  1  TX request; accepted when busy_tx=0.
- data_tx  in  DATA_BITS  TX payload, sampled on accept.
- busy_tx  out  1  TX frame in progress.
- tx  out  1  serial out, idle high.
- rx  in  1  serial in, asynchronous to clk.
- rx_pop  in  1  pop FIFO head; ignored when rx_valid=0.
- rx_valid  out  1  FIFO non-empty.
- data_rx  out  DATA_BITS  FIFO head payload.
- frame_err  out  1  FIFO head had stop bit = 0.
- parity_err  out  1  FIFO head failed parity (always 0 when PARITY=0).
- overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- ovr_clr  in  1  clears overrun.

Behaviour:
- Reset (nRst low, asynchronous):
  - tx=1, busy_tx=0, rx_valid=0, data_rx=0, frame_err=0, parity_err=0, overrun=0.
  - FIFO pointers and both FSMs return to IDLE.
  - Reset mid-frame aborts the frame; no partial byte is pushed.
- TX FSM, states IDLE→START→DATA→PARITY (skipped if PARITY=0)→STOP→IDLE:
  - In IDLE, transmit=1 latches data_tx. On the next edge busy_tx=1 and tx=0 (start bit).
  - Each bit lasts exactly CLKS_PER_BIT cycles. Data is sent LSB first.
  - Parity bit: odd mode makes the total count of ones (data + parity) odd; even mode makes it even.
  - STOP holds tx=1 for STOP_BITS×CLKS_PER_BIT cycles. busy_tx falls on the edge that ends the last stop bit.
  - Total busy time = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS)×CLKS_PER_BIT cycles.
  - transmit held high continuously sends back-to-back frames with one idle cycle between them (the IDLE accept cycle).
  - transmit while busy_tx=1 is ignored.
- RX path:
  - rx passes through a 2-flop synchroniser before any use.
  - FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a synchronised 1→0 transition enters START and loads the counter with CLKS_PER_BIT/2.
  - Mid-start: if the line is back to 1, treat it as a glitch and return to IDLE with no push and no error.
  - Sampling: data, parity and the first stop bit are each sampled at bit centre, every CLKS_PER_BIT cycles after mid-start.
  - Only the first stop bit is checked. frame_err = (stop sample == 0).
  - The push happens on the first-stop-bit sample cycle; the FSM then returns to IDLE immediately so it can resynchronise on the next start edge.
  - With STOP_BITS=2, a missing second stop bit is not flagged.
- FIFO:
  - Entry width = DATA_BITS+2; stores {parity_err, frame_err, data}.
  - Show-ahead: the head is visible on data_rx, frame_err and parity_err while rx_valid=1.
  - rx_pop with rx_valid=1 advances the head next cycle.
  - Simultaneous push and pop is legal at any fill level, including full: the count is unchanged and no overrun is flagged.
  - Push when full with no pop: the frame is discarded and overrun is set.
  - Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit or a count.
- overrun:
  - Stays set until ovr_clr=1 or reset.
  - If ovr_clr and a new overrun occur in the same cycle, the set wins.
- The TX and RX paths are fully independent. Loopback (tx wired to rx) must work.

Test Plan:
- Reset and idle: CLK_HZ=16, BAUD=1, defaults otherwise. Assert nRst low, release → tx=1, busy_tx=0, rx_valid=0, overrun=0. Idle 100 cycles → no change.
- TX frame 8N1: transmit pulse with data_tx=8'hAA → tx sequence 0,0,1,0,1,0,1,0,1,1, each bit held 16 cycles; busy_tx high for exactly 160 cycles.
- Loopback 8E2, PARITY=2, STOP_BITS=2: send 8'h5A, 8'h01, 8'hFF back-to-back → FIFO holds the same three values in order. Parity bits on the wire are 0, 1, 0. All error flags 0.
- Error injection: drive an rx frame 8'h3C with the stop bit forced 0 → entry with frame_err=1. Drive 8O1 with a wrong parity bit → entry with parity_err=1. A 3-cycle low glitch on rx → no entry.
- Overflow, FIFO_DEPTH=4: receive 5 frames with no pop → rx_valid=1, 4 entries 0x10..0x13 readable in order, overrun=1. Pulse ovr_clr → overrun=0.
- Mid-frame reset, plus push and pop with the FIFO full: assert nRst during the 4th data bit of TX and RX → tx=1 and FSMs idle, no entry. With the FIFO full, pop on the same cycle a frame completes → count stays 4, overrun stays 0.
